// File: rtl/spi_accel_responder_pkg.sv
// Shared types and constants for the SPI accelerometer register responder:
// FSM state encoding, register map addresses and RW register reset values.
package spi_accel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } state_e;

  localparam logic [5:0] ADDR_DEVID       = 6'h00;
  localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
  localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
  localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [5:0] ADDR_DATAX0      = 6'h32;
  localparam logic [5:0] ADDR_DATAX1      = 6'h33;
  localparam logic [5:0] ADDR_DATAY0      = 6'h34;
  localparam logic [5:0] ADDR_DATAY1      = 6'h35;
  localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
  localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

  localparam logic [7:0] BW_RATE_RST     = 8'h0A;
  localparam logic [7:0] POWER_CTL_RST   = 8'h00;
  localparam logic [7:0] DATA_FORMAT_RST = 8'h00;

  // True for the addresses a master is allowed to write.
  function automatic logic is_rw_addr(input logic [5:0] addr);
    return (addr == ADDR_BW_RATE) || (addr == ADDR_POWER_CTL) ||
           (addr == ADDR_DATA_FORMAT);
  endfunction

endpackage

// File: rtl/spi_accel_responder_if.sv
// SPI pins between the bus master and the responder. miso_oe tells the
// board top when to drive miso; otherwise the pin is tri-stated there.
interface spi_accel_responder_if;
  logic sclk;
  logic ss_n;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sclk, output ss_n, output mosi,
                  input miso, input miso_oe);
  modport slave  (input sclk, input ss_n, input mosi,
                  output miso, output miso_oe);
endinterface

// File: rtl/spi_accel_responder_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with single-cycle
// rise/fall pulses derived from the synchronized level.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the raw input through the chain; keep last level for edge detect.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  // Edge pulses are combinational off the last stage so a consumer can
  // register the reaction one cycle after the level settles.
  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_accel_responder.sv
// SPI mode-3 register responder emulating a small accelerometer register
// file. SPI pins are oversampled on CLOCK_50; a command byte selects
// read/write, multi-byte mode and a 6-bit start address.
module spi_accel_responder
  import spi_accel_pkg::*;
#(
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                 CLOCK_50,
  input  logic                 reset_n,
  spi_accel_responder_if.slave spi,
  input  logic                 sample_valid,
  input  logic signed [15:0]   data_x,
  input  logic signed [15:0]   data_y,
  input  logic signed [15:0]   data_z,
  output logic [7:0]           bw_rate,
  output logic [7:0]           power_ctl,
  output logic [7:0]           data_format,
  output logic                 wr_stb,
  output logic [5:0]           wr_addr,
  output logic [7:0]           wr_data,
  output logic                 busy
);

  // Synchronized SPI pins and their edge pulses.
  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic ss_level, ss_rise, ss_fall;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
    .clk_i(CLOCK_50), .rst_n_i(reset_n), .d_i(spi.sclk),
    .q_o(sclk_level_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk_i(CLOCK_50), .rst_n_i(reset_n), .d_i(spi.ss_n),
    .q_o(ss_level), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk_i(CLOCK_50), .rst_n_i(reset_n), .d_i(spi.mosi),
    .q_o(mosi_level), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  state_e      state_q;
  logic [2:0]  bit_cnt_q;
  logic [6:0]  shift_in_q;
  logic [7:0]  shift_out_q;
  logic        miso_q;
  logic [5:0]  addr_q;
  logic        mb_q;
  logic        first_q;
  logic [7:0]  bw_rate_q, power_ctl_q, data_format_q;
  logic        wr_stb_q;
  logic [5:0]  wr_addr_q;
  logic [7:0]  wr_data_q;
  logic [15:0] live_x_q, live_y_q, live_z_q;
  logic [15:0] shadow_x_q, shadow_y_q, shadow_z_q;

  // The byte as it stands once the current rising-edge bit is included.
  logic [7:0] rx_byte_d;
  logic [5:0] addr_inc_d;
  assign rx_byte_d  = {shift_in_q, mosi_level};
  assign addr_inc_d = addr_q + 6'd1;

  // Register map read mux; sample bytes come from the shadow copy so a
  // burst always returns one coherent sample.
  function automatic logic [7:0] reg_read(input logic [5:0] addr);
    case (addr)
      ADDR_DEVID:       return DEVID;
      ADDR_BW_RATE:     return bw_rate_q;
      ADDR_POWER_CTL:   return power_ctl_q;
      ADDR_DATA_FORMAT: return data_format_q;
      ADDR_DATAX0:      return shadow_x_q[7:0];
      ADDR_DATAX1:      return shadow_x_q[15:8];
      ADDR_DATAY0:      return shadow_y_q[7:0];
      ADDR_DATAY1:      return shadow_y_q[15:8];
      ADDR_DATAZ0:      return shadow_z_q[7:0];
      ADDR_DATAZ1:      return shadow_z_q[15:8];
      default:          return 8'h00;
    endcase
  endfunction

  // Capture every new sample into the live registers regardless of state.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      live_x_q <= '0;
      live_y_q <= '0;
      live_z_q <= '0;
    end else if (sample_valid) begin
      live_x_q <= data_x;
      live_y_q <= data_y;
      live_z_q <= data_z;
    end
  end

  // Transaction FSM with shift registers, register file and write strobe.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      shift_in_q    <= '0;
      shift_out_q   <= '0;
      miso_q        <= 1'b0;
      addr_q        <= '0;
      mb_q          <= 1'b0;
      first_q       <= 1'b0;
      bw_rate_q     <= BW_RATE_RST;
      power_ctl_q   <= POWER_CTL_RST;
      data_format_q <= DATA_FORMAT_RST;
      wr_stb_q      <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      shadow_x_q    <= '0;
      shadow_y_q    <= '0;
      shadow_z_q    <= '0;
    end else begin
      wr_stb_q <= 1'b0;
      if (ss_rise) begin
        // Deselect aborts whatever is in flight; partial bytes vanish.
        state_q   <= IDLE;
        bit_cnt_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (ss_fall) begin
              state_q     <= CMD;
              bit_cnt_q   <= '0;
              shift_out_q <= '0;
              miso_q      <= 1'b0;
              // A sample arriving on this very cycle wins over the live copy.
              shadow_x_q  <= sample_valid ? data_x : live_x_q;
              shadow_y_q  <= sample_valid ? data_y : live_y_q;
              shadow_z_q  <= sample_valid ? data_z : live_z_q;
            end
          end
          default: begin
            if (sclk_fall) begin
              miso_q      <= shift_out_q[7];
              shift_out_q <= {shift_out_q[6:0], 1'b0};
            end
            if (sclk_rise) begin
              shift_in_q <= rx_byte_d[6:0];
              bit_cnt_q  <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                case (state_q)
                  CMD: begin
                    addr_q  <= rx_byte_d[5:0];
                    mb_q    <= rx_byte_d[6];
                    first_q <= 1'b1;
                    if (rx_byte_d[7]) begin
                      state_q     <= READ;
                      shift_out_q <= reg_read(rx_byte_d[5:0]);
                    end else begin
                      state_q <= WRITE;
                    end
                  end
                  READ: begin
                    first_q <= 1'b0;
                    if (mb_q) begin
                      addr_q      <= addr_inc_d;
                      shift_out_q <= reg_read(addr_inc_d);
                    end else begin
                      shift_out_q <= 8'h00;
                    end
                  end
                  WRITE: begin
                    first_q <= 1'b0;
                    if (mb_q || first_q) begin
                      if (mb_q) addr_q <= addr_inc_d;
                      if (is_rw_addr(addr_q)) begin
                        wr_stb_q  <= 1'b1;
                        wr_addr_q <= addr_q;
                        wr_data_q <= rx_byte_d;
                        case (addr_q)
                          ADDR_BW_RATE:   bw_rate_q     <= rx_byte_d;
                          ADDR_POWER_CTL: power_ctl_q   <= rx_byte_d;
                          default:        data_format_q <= rx_byte_d;
                        endcase
                      end
                    end
                  end
                  default: ;
                endcase
              end
            end
          end
        endcase
      end
    end
  end

  assign spi.miso    = miso_q;
  assign spi.miso_oe = ~ss_level;
  assign busy        = ~ss_level;
  assign bw_rate     = bw_rate_q;
  assign power_ctl   = power_ctl_q;
  assign data_format = data_format_q;
  assign wr_stb      = wr_stb_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;

endmodule

// File: tb/tb_spi_accel_responder.sv
// Directed bench for spi_accel_responder: a table of SPI transactions with
// expected read bytes, write strobes and register contents, plus hand-made
// sequences for the coherent sample burst and a mid-transaction reset.
module tb_spi_accel_responder;

  logic CLOCK_50 = 1'b0;
  logic reset_n  = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  spi_accel_responder_if spi_if();

  logic               sample_valid = 1'b0;
  logic signed [15:0] data_x = '0, data_y = '0, data_z = '0;
  logic [7:0]         bw_rate, power_ctl, data_format;
  logic               wr_stb, busy;
  logic [5:0]         wr_addr;
  logic [7:0]         wr_data;

  spi_accel_responder #(.DEVID(8'hE5), .SYNC_STAGES(2)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .spi(spi_if),
    .sample_valid(sample_valid), .data_x(data_x), .data_y(data_y),
    .data_z(data_z), .bw_rate(bw_rate), .power_ctl(power_ctl),
    .data_format(data_format), .wr_stb(wr_stb), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write strobe monitor, sampled away from the active edge.
  int         wr_cnt = 0;
  logic [5:0] last_wa = '0;
  logic [7:0] last_wd = '0;
  always @(negedge CLOCK_50) begin
    if (wr_stb === 1'b1) begin
      wr_cnt++;
      last_wa = wr_addr;
      last_wd = wr_data;
    end
  end

  logic [7:0] tx_buf [8];
  logic [7:0] rx_buf [8];

  // Half an SCLK period: 8 system clocks, above the 5-cycle minimum.
  task automatic half();
    repeat (8) @(negedge CLOCK_50);
  endtask

  // One mode-3 bit: master drives mosi on the falling edge, samples miso
  // just before the rising edge.
  task automatic spi_bit(input logic b, output logic r);
    spi_if.sclk = 1'b0;
    spi_if.mosi = b;
    half();
    r = spi_if.miso;
    spi_if.sclk = 1'b1;
    half();
  endtask

  task automatic spi_xfer(input int nbits);
    logic r;
    for (int k = 0; k < 8; k++) rx_buf[k] = 8'h00;
    spi_if.ss_n = 1'b0;
    half();
    for (int i = 0; i < nbits; i++) begin
      spi_bit(tx_buf[i/8][7-(i%8)], r);
      rx_buf[i/8][7-(i%8)] = r;
    end
    half();
    spi_if.ss_n = 1'b1;
    repeat (10) @(negedge CLOCK_50);
  endtask

  typedef struct {
    string       name;
    logic [63:0] tx;       // byte k at [63-8k -: 8]
    int          nbits;
    logic [63:0] exp_rx;
    logic [7:0]  rx_mask;  // bit 7-k enables the check of byte k
    int          exp_wr;   // write strobes expected in this transaction
    logic [5:0]  exp_wa;
    logic [7:0]  exp_wd;
    logic [7:0]  exp_bw, exp_pc, exp_df;
  } vec_t;

  function automatic vec_t mk(input string name, input logic [63:0] tx,
                              input int nbits, input logic [63:0] exp_rx,
                              input logic [7:0] rx_mask, input int exp_wr,
                              input logic [5:0] exp_wa, input logic [7:0] exp_wd,
                              input logic [7:0] exp_bw, input logic [7:0] exp_pc,
                              input logic [7:0] exp_df);
    vec_t v;
    v.name = name; v.tx = tx; v.nbits = nbits; v.exp_rx = exp_rx;
    v.rx_mask = rx_mask; v.exp_wr = exp_wr; v.exp_wa = exp_wa;
    v.exp_wd = exp_wd; v.exp_bw = exp_bw; v.exp_pc = exp_pc; v.exp_df = exp_df;
    return v;
  endfunction

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  initial begin
    int wr_before;
    logic r;
    logic [7:0] dbyte;

    spi_if.sclk = 1'b1;
    spi_if.ss_n = 1'b1;
    spi_if.mosi = 1'b0;

    vecs[0]  = mk("rd_devid",  {8'h80, 8'h00, 48'h0},        16, {8'h00, 8'hE5, 48'h0},        8'h40, 0, 6'h00, 8'h00, 8'h0A, 8'h00, 8'h00);
    vecs[1]  = mk("wr_pwr",    {8'h2D, 8'h08, 48'h0},        16, 64'h0,                        8'h00, 1, 6'h2D, 8'h08, 8'h0A, 8'h08, 8'h00);
    vecs[2]  = mk("rd_pwr",    {8'hAD, 8'h00, 48'h0},        16, {8'h00, 8'h08, 48'h0},        8'h40, 0, 6'h00, 8'h00, 8'h0A, 8'h08, 8'h00);
    vecs[3]  = mk("rd_wrap",   {8'hFF, 8'h00, 8'h00, 40'h0}, 24, {8'h00, 8'h00, 8'hE5, 40'h0}, 8'h60, 0, 6'h00, 8'h00, 8'h0A, 8'h08, 8'h00);
    vecs[4]  = mk("wr_part",   {8'h31, 8'hFF, 48'h0},        13, 64'h0,                        8'h00, 0, 6'h00, 8'h00, 8'h0A, 8'h08, 8'h00);
    vecs[5]  = mk("rd_fmt",    {8'hB1, 8'h00, 48'h0},        16, {8'h00, 8'h00, 48'h0},        8'h40, 0, 6'h00, 8'h00, 8'h0A, 8'h08, 8'h00);
    vecs[6]  = mk("rd_bw_sb",  {8'hAC, 8'h00, 8'h00, 40'h0}, 24, {8'h00, 8'h0A, 8'h00, 40'h0}, 8'h60, 0, 6'h00, 8'h00, 8'h0A, 8'h08, 8'h00);
    vecs[7]  = mk("wr_mb",     {8'h6C, 8'h11, 8'h22, 40'h0}, 24, 64'h0,                        8'h00, 2, 6'h2D, 8'h22, 8'h11, 8'h22, 8'h00);
    vecs[8]  = mk("wr_ro",     {8'h00, 8'h55, 48'h0},        16, 64'h0,                        8'h00, 0, 6'h00, 8'h00, 8'h11, 8'h22, 8'h00);
    vecs[9]  = mk("wr_sb2",    {8'h2C, 8'h33, 8'h44, 40'h0}, 24, 64'h0,                        8'h00, 1, 6'h2C, 8'h33, 8'h33, 8'h22, 8'h00);
    vecs[10] = mk("rd_mb_rw",  {8'hEC, 8'h00, 8'h00, 40'h0}, 24, {8'h00, 8'h33, 8'h22, 40'h0}, 8'h60, 0, 6'h00, 8'h00, 8'h33, 8'h22, 8'h00);
    vecs[11] = mk("wr_fmt",    {8'h31, 8'h0B, 48'h0},        16, 64'h0,                        8'h00, 1, 6'h31, 8'h0B, 8'h33, 8'h22, 8'h0B);
    vecs[12] = mk("rd_unmap",  {8'h85, 8'h00, 48'h0},        16, {8'h00, 8'h00, 48'h0},        8'h40, 0, 6'h00, 8'h00, 8'h33, 8'h22, 8'h0B);

    // Reset state, observed while reset is still held.
    repeat (3) @(negedge CLOCK_50);
    check("rst_bw_rate", bw_rate, 8'h0A);
    check("rst_power_ctl", power_ctl, 8'h00);
    check("rst_data_format", data_format, 8'h00);
    check("rst_miso", spi_if.miso, 1'b0);
    check("rst_miso_oe", spi_if.miso_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_stb", wr_stb, 1'b0);
    check("rst_wr_addr", wr_addr, 6'h00);
    check("rst_wr_data", wr_data, 8'h00);
    reset_n = 1'b1;
    repeat (5) @(negedge CLOCK_50);

    // Table-driven transactions.
    for (int v = 0; v < NVEC; v++) begin
      for (int k = 0; k < 8; k++) tx_buf[k] = vecs[v].tx[63-8*k -: 8];
      wr_before = wr_cnt;
      spi_xfer(vecs[v].nbits);
      for (int k = 0; k < 8; k++)
        if (vecs[v].rx_mask[7-k])
          check($sformatf("%s_rx%0d", vecs[v].name, k), rx_buf[k],
                vecs[v].exp_rx[63-8*k -: 8]);
      check($sformatf("%s_wrcnt", vecs[v].name), wr_cnt - wr_before, vecs[v].exp_wr);
      if (vecs[v].exp_wr > 0) begin
        check($sformatf("%s_wraddr", vecs[v].name), last_wa, vecs[v].exp_wa);
        check($sformatf("%s_wrdata", vecs[v].name), last_wd, vecs[v].exp_wd);
      end
      check($sformatf("%s_bw", vecs[v].name), bw_rate, vecs[v].exp_bw);
      check($sformatf("%s_pc", vecs[v].name), power_ctl, vecs[v].exp_pc);
      check($sformatf("%s_df", vecs[v].name), data_format, vecs[v].exp_df);
      check($sformatf("%s_idle_oe", vecs[v].name), spi_if.miso_oe, 1'b0);
      $display("vec %0d %s: rx %h %h %h wr_cnt %0d", v, vecs[v].name,
               rx_buf[0], rx_buf[1], rx_buf[2], wr_cnt);
    end

    // Coherent 6-byte sample burst with a new sample arriving mid-burst.
    data_x = 16'h1234; data_y = 16'hFFFE; data_z = 16'h0100;
    sample_valid = 1'b1;
    @(negedge CLOCK_50);
    sample_valid = 1'b0;
    tx_buf[0] = 8'hF2;
    for (int k = 1; k < 8; k++) tx_buf[k] = 8'h00;
    fork
      spi_xfer(56);
      begin
        repeat (300) @(negedge CLOCK_50);
        data_x = 16'hAAAA; data_y = 16'hBBBB; data_z = 16'hCCCC;
        sample_valid = 1'b1;
        @(negedge CLOCK_50);
        sample_valid = 1'b0;
      end
    join
    check("burst_x0", rx_buf[1], 8'h34);
    check("burst_x1", rx_buf[2], 8'h12);
    check("burst_y0", rx_buf[3], 8'hFE);
    check("burst_y1", rx_buf[4], 8'hFF);
    check("burst_z0", rx_buf[5], 8'h00);
    check("burst_z1", rx_buf[6], 8'h01);
    $display("burst: %h %h %h %h %h %h", rx_buf[1], rx_buf[2], rx_buf[3],
             rx_buf[4], rx_buf[5], rx_buf[6]);

    // The mid-burst sample reaches the shadow on the next select.
    tx_buf[0] = 8'hB2; tx_buf[1] = 8'h00;
    spi_xfer(16);
    check("new_x0", rx_buf[1], 8'hAA);
    tx_buf[0] = 8'hB7;
    spi_xfer(16);
    check("new_z1", rx_buf[1], 8'hCC);
    $display("new sample: x0 via 0xB2 and z1 via 0xB7 read back %h", rx_buf[1]);

    // Reset pulsed in the middle of a write to bw_rate.
    wr_before = wr_cnt;
    spi_if.ss_n = 1'b0;
    half();
    check("sel_miso_oe", spi_if.miso_oe, 1'b1);
    check("sel_busy", busy, 1'b1);
    dbyte = 8'h2C;
    for (int i = 0; i < 8; i++) spi_bit(dbyte[7-i], r);
    dbyte = 8'h5A;
    for (int i = 0; i < 3; i++) spi_bit(dbyte[7-i], r);
    @(negedge CLOCK_50);
    reset_n = 1'b0;
    #1;
    check("arst_bw_rate", bw_rate, 8'h0A);
    check("arst_power_ctl", power_ctl, 8'h00);
    check("arst_miso_oe", spi_if.miso_oe, 1'b0);
    check("arst_busy", busy, 1'b0);
    spi_if.ss_n = 1'b1;
    spi_if.sclk = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    reset_n = 1'b1;
    repeat (10) @(negedge CLOCK_50);
    check("arst_no_wr", wr_cnt - wr_before, 0);
    $display("mid-write reset: bw_rate %h miso_oe %b", bw_rate, spi_if.miso_oe);

    tx_buf[0] = 8'h80; tx_buf[1] = 8'h00;
    spi_xfer(16);
    check("post_rst_devid", rx_buf[1], 8'hE5);
    wr_before = wr_cnt;
    tx_buf[0] = 8'h2C; tx_buf[1] = 8'h5A;
    spi_xfer(16);
    check("post_rst_wrcnt", wr_cnt - wr_before, 1);
    check("post_rst_bw", bw_rate, 8'h5A);
    check("post_rst_wraddr", last_wa, 6'h2C);
    $display("post-reset: devid %h bw_rate %h", 8'hE5, bw_rate);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
